rr_bus_arbiter: RTL and testbench

Eight-way round-robin arbiter that sequences access to a shared bus whose chip selects follow the team's active-low 3-to-8 decode convention. It sits between the eight requesting units and the shared resource. It registers a single winner and drives both the 3-bit index and the active-low one-hot select. Grants are released on request drop or hold timeout, followed by one bus-turnaround cycle.

---
 rtl/rr_bus_arbiter.sv | 107 ++++++++++
 tb/tb_rr_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - eight-way round-robin bus arbiter with active-low one-hot select
module rr_bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic       gnt_vld,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hold_cnt;
    logic [2:0] search_ptr;
    logic [2:0] winner;
    logic       timeout;

    // First requester at or after p, wrapping mod 8; descending scan so the
    // smallest offset from p is the last one to overwrite the result.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] c;
        pick = p;
        for (int i = 7; i >= 0; i--) begin
            c = p + 3'(i);
            if (r[c]) pick = c;
        end
    endfunction

    function automatic logic [7:0] decode_n(input logic [2:0] i);
        decode_n = ~(8'b0000_0001 << i);
    endfunction

    // In RELEASE the pointer update and the re-arbitration happen on the same
    // edge, so search from the post-release pointer directly.
    always_comb begin
        search_ptr = (state == RELEASE) ? (gnt_idx + 3'd1) : ptr;
        winner     = pick(req, search_ptr);
        timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= 8'd0;
            gnt_vld  <= 1'b0;
            gnt_idx  <= 3'd0;
            gnt_n    <= 8'hFF;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (req != 8'd0)) begin
                        state    <= GRANT;
                        gnt_vld  <= 1'b1;
                        gnt_idx  <= winner;
                        gnt_n    <= decode_n(winner);
                        busy     <= 1'b1;
                        hold_cnt <= 8'd1;
                    end
                end
                GRANT: begin
                    if (!req[gnt_idx] || timeout) begin
                        state    <= RELEASE;
                        gnt_vld  <= 1'b0;
                        gnt_n    <= 8'hFF;
                        hold_cnt <= 8'd0;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    ptr <= gnt_idx + 3'd1;
                    if (en && (req != 8'd0)) begin
                        state    <= GRANT;
                        gnt_vld  <= 1'b1;
                        gnt_idx  <= winner;
                        gnt_n    <= decode_n(winner);
                        hold_cnt <= 8'd1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gnt_vld <= 1'b0;
                    gnt_n   <= 8'hFF;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - randomized and directed check of rr_bus_arbiter against a behavioural model
module tb_rr_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;

    logic       vld_w  [4];
    logic [2:0] idx_w  [4];
    logic [7:0] gn_w   [4];
    logic       busy_w [4];

    int mh [4] = '{16, 4, 1, 0};

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.MAX_HOLD(16)) d16 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt_vld(vld_w[0]), .gnt_idx(idx_w[0]), .gnt_n(gn_w[0]), .busy(busy_w[0]));
    rr_bus_arbiter #(.MAX_HOLD(4)) d4 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt_vld(vld_w[1]), .gnt_idx(idx_w[1]), .gnt_n(gn_w[1]), .busy(busy_w[1]));
    rr_bus_arbiter #(.MAX_HOLD(1)) d1 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt_vld(vld_w[2]), .gnt_idx(idx_w[2]), .gnt_n(gn_w[2]), .busy(busy_w[2]));
    rr_bus_arbiter #(.MAX_HOLD(0)) d0 (.clk(clk), .rst(rst), .en(en), .req(req),
        .gnt_vld(vld_w[3]), .gnt_idx(idx_w[3]), .gnt_n(gn_w[3]), .busy(busy_w[3]));

    task automatic chk(input string name, input int k, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s dut%0d got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: owner/dead-cycle/held-count bookkeeping in plain integers.
    bit mvld  [4];
    bit mdead [4];
    int midx  [4];
    int mheld [4];
    int mptr  [4];
    bit started = 1'b0;

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int o = 0; o < 8; o++)
            if (r[(p + o) % 8]) return (p + o) % 8;
        return p;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                mvld[k] = 0; mdead[k] = 0; midx[k] = 0; mheld[k] = 0; mptr[k] = 0;
            end else if (mvld[k]) begin
                if (!req[midx[k]] || (mh[k] != 0 && mheld[k] == mh[k])) begin
                    mvld[k] = 0;
                    mdead[k] = 1;
                end else if (mheld[k] < 255) begin
                    mheld[k]++;
                end
            end else begin
                if (mdead[k]) begin
                    mdead[k] = 0;
                    mptr[k] = (midx[k] + 1) % 8;
                end
                if (en && req != 8'd0) begin
                    mvld[k] = 1;
                    midx[k] = first_from(req, mptr[k]);
                    mheld[k] = 1;
                end
            end
        end
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 4; k++) begin
                chk("gnt_vld", k, int'(vld_w[k]), int'(mvld[k]));
                chk("gnt_idx", k, int'(idx_w[k]), midx[k]);
                chk("gnt_n", k, int'(gn_w[k]), mvld[k] ? int'(8'hFF ^ (8'd1 << midx[k])) : 32'hFF);
                chk("busy", k, int'(busy_w[k]), int'(mvld[k] | mdead[k]));
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wait_for(input int k, input logic want);
        int n;
        n = 0;
        while (vld_w[k] !== want && n < 40) begin
            nxt();
            n++;
        end
        chk("wait_vld", k, int'(vld_w[k]), int'(want));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    int cnt, ngr, nr;
    logic pv;
    int seq [16];
    int ridx [8];
    int rlen [8];

    initial begin
        rst = 1'b1; en = 1'b0; req = 8'd0;
        nxt(); nxt();
        rst = 1'b0;
        nxt();
        chk("rst_vld", 0, int'(vld_w[0]), 0);
        chk("rst_gn", 0, int'(gn_w[0]), 32'hFF);
        chk("rst_busy", 0, int'(busy_w[0]), 0);

        // Single requester held four sampled cycles, then dropped.
        en = 1'b1; req = 8'h08; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            cnt += int'(vld_w[0]);
            chk("single_idx", 0, int'(idx_w[0]), 3);
            chk("single_gn", 0, int'(gn_w[0]), 32'hF7);
        end
        req = 8'h00;
        nxt();
        chk("single_cnt", 0, cnt, 4);
        chk("single_dead_gn", 0, int'(gn_w[0]), 32'hFF);
        chk("single_dead_busy", 0, int'(busy_w[0]), 1);
        nxt();

        // Reset in the middle of a grant to index 5.
        req = 8'h20;
        nxt();
        chk("mid_vld", 0, int'(vld_w[0]), 1);
        chk("mid_idx", 0, int'(idx_w[0]), 5);
        rst = 1'b1;
        nxt();
        chk("mid_rst_vld", 0, int'(vld_w[0]), 0);
        chk("mid_rst_gn", 0, int'(gn_w[0]), 32'hFF);
        chk("mid_rst_busy", 0, int'(busy_w[0]), 0);
        rst = 1'b0; req = 8'h01;
        nxt();
        chk("post_rst_vld", 0, int'(vld_w[0]), 1);
        chk("post_rst_idx", 0, int'(idx_w[0]), 0);
        req = 8'h00;
        nxt(); nxt(); nxt();

        // All requesting with MAX_HOLD=1.
        do_reset();
        req = 8'hFF; ngr = 0; pv = 1'b0;
        for (int i = 0; i < 18; i++) begin
            nxt();
            if (vld_w[2] && !pv && ngr < 16) begin
                seq[ngr] = int'(idx_w[2]);
                ngr++;
            end
            pv = vld_w[2];
        end
        chk("rr_count", 2, ngr, 9);
        for (int j = 0; j < 9; j++) chk("rr_seq", 2, seq[j], j % 8);
        req = 8'h00;
        nxt(); nxt();

        // Wrap-around: serve 6, then 7 must precede 0.
        do_reset();
        req = 8'h40;
        nxt();
        chk("wrap_idx6", 0, int'(idx_w[0]), 6);
        req = 8'h81;
        wait_for(0, 1'b0);
        wait_for(0, 1'b1);
        chk("wrap_idx7", 0, int'(idx_w[0]), 7);
        req = 8'h01;
        wait_for(0, 1'b0);
        wait_for(0, 1'b1);
        chk("wrap_idx0", 0, int'(idx_w[0]), 0);
        req = 8'h00;
        nxt(); nxt();

        // Timeout with MAX_HOLD=4 and two continuous requesters.
        do_reset();
        req = 8'h06; nr = 0; pv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            nxt();
            if (vld_w[1]) begin
                if (!pv && nr < 8) begin
                    ridx[nr] = int'(idx_w[1]);
                    rlen[nr] = 1;
                    nr++;
                end else if (pv) begin
                    rlen[nr-1]++;
                end
            end
            pv = vld_w[1];
        end
        chk("to_runs", 1, nr, 3);
        chk("to_idx0", 1, ridx[0], 1);
        chk("to_len0", 1, rlen[0], 4);
        chk("to_idx1", 1, ridx[1], 2);
        chk("to_len1", 1, rlen[1], 4);
        chk("to_idx2", 1, ridx[2], 1);
        req = 8'h00;
        nxt(); nxt();

        // Enable gating.
        do_reset();
        en = 1'b0; req = 8'h10;
        nxt(); nxt(); nxt();
        chk("en_off_vld", 0, int'(vld_w[0]), 0);
        chk("en_off_busy", 0, int'(busy_w[0]), 0);
        en = 1'b1;
        nxt();
        chk("en_on_vld", 0, int'(vld_w[0]), 1);
        chk("en_on_idx", 0, int'(idx_w[0]), 4);
        en = 1'b0; req = 8'h13;
        nxt(); nxt(); nxt();
        chk("en_drop_vld", 0, int'(vld_w[0]), 1);
        chk("en_drop_idx", 0, int'(idx_w[0]), 4);
        req = 8'h03;
        nxt();
        chk("en_rel_vld", 0, int'(vld_w[0]), 0);
        chk("en_rel_busy", 0, int'(busy_w[0]), 1);
        nxt();
        chk("en_idle_vld", 0, int'(vld_w[0]), 0);
        chk("en_idle_busy", 0, int'(busy_w[0]), 0);
        nxt();
        chk("en_idle2_vld", 0, int'(vld_w[0]), 0);

        // Random traffic with sticky request bits so long holds occur.
        for (int c = 0; c < 4000; c++) begin
            nxt();
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0)
                req = 8'($urandom);
            else
                for (int b = 0; b < 8; b++)
                    if ($urandom_range(0, 11) == 0) req[b] = ~req[b];
        end
        rst = 1'b0;
        nxt(); nxt();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
